// File: rtl/noise_keyer_pkg.sv
// Shared types and constants for the noise keyer: FSM encoding, the idle DAC
// pattern and the level helpers used by the mask generator.
package noise_keyer_pkg;

  localparam int LVL_W     = 5;
  localparam int LEVEL_MAX = 16;
  localparam logic [15:0] STATIC_PATTERN = 16'hAAAA;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_GAP       = 3'd4
  } keyer_state_e;

  function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] lvl);
    return (lvl > LVL_W'(LEVEL_MAX)) ? LVL_W'(LEVEL_MAX) : lvl;
  endfunction

  // Thermometer mask: bit i carries noise when i < lvl.
  function automatic logic [15:0] noise_mask(input logic [LVL_W-1:0] lvl);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = (i < int'(lvl));
    return m;
  endfunction

endpackage

// File: rtl/keyer_step_gen.sv
// Ramp-step prescaler: pulses step once every DIV clocks, restartable so each
// FSM state begins with a full step period.
module keyer_step_gen #(
  parameter int DIV = 50
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic restart,
  output logic step
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                         cnt_reg <= '0;
    else if (restart || cnt_reg == LAST) cnt_reg <= '0;
    else                                cnt_reg <= cnt_reg + 1'b1;
  end

  assign step = (cnt_reg == LAST);

endmodule

// File: rtl/noise_keyer.sv
// Noise burst keyer feeding the 16-bit resistor DAC. Define NOISE_KEYER_RAMP_EN
// for stepped amplitude ramps; otherwise ramps collapse to a single cycle.
module noise_keyer
  import noise_keyer_pkg::*;
#(
  parameter int RAMP_DIV = 50,
  parameter int CNT_W    = 24
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [15:0]      noise_in,
  input  logic             enable,
  input  logic [4:0]       level,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  output logic [15:0]      dac,
  output logic [4:0]       cur_level,
  output logic [2:0]       state,
  output logic             burst_start
);

  keyer_state_e     state_reg, state_next;
  logic [LVL_W-1:0] lvl_reg, lvl_next, target_reg, live_target, lvl_inc;
  logic [CNT_W-1:0] cnt_reg, cnt_next, on_reg, off_reg;
  logic             load;
  logic [15:0]      mask;

  assign live_target = clamp_level(level);
  assign lvl_inc     = lvl_reg + 5'd1;
  assign mask        = noise_mask(lvl_reg);
  assign cur_level   = lvl_reg;
  assign state       = state_reg;

`ifdef NOISE_KEYER_RAMP_EN
  logic step;
  keyer_step_gen #(.DIV(RAMP_DIV)) u_step (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .restart (state_next != state_reg),
    .step    (step)
  );
`else
  logic div_unused;
  assign div_unused = (RAMP_DIV > 0);
`endif

  always_comb begin
    state_next = state_reg;
    lvl_next   = lvl_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      S_OFF: begin
        lvl_next = '0;
        if (enable) begin
          state_next = S_RAMP_UP;
          load       = 1'b1;
        end
      end
      S_RAMP_UP: begin
        // Dropping enable wins over a coincident step so the ramp-down starts level.
        if (!enable) state_next = S_RAMP_DOWN;
`ifdef NOISE_KEYER_RAMP_EN
        else if (step) begin
          if (lvl_reg < target_reg) lvl_next = lvl_inc;
          if (lvl_inc >= target_reg) state_next = S_ON;
        end
`else
        else begin
          lvl_next   = target_reg;
          state_next = S_ON;
        end
`endif
      end
      S_ON: begin
        if (!enable) state_next = S_RAMP_DOWN;
        else if (on_reg == '0) begin
`ifdef NOISE_KEYER_RAMP_EN
          if (step) begin
            if (lvl_reg < live_target)      lvl_next = lvl_inc;
            else if (lvl_reg > live_target) lvl_next = lvl_reg - 5'd1;
          end
`else
          lvl_next = live_target;
`endif
        end
        else if (cnt_reg == on_reg - 1'b1) state_next = S_RAMP_DOWN;
        else cnt_next = cnt_reg + 1'b1;
      end
      S_RAMP_DOWN: begin
`ifdef NOISE_KEYER_RAMP_EN
        if (lvl_reg == '0) state_next = enable ? S_GAP : S_OFF;
        else if (step)     lvl_next = lvl_reg - 5'd1;
`else
        lvl_next   = '0;
        state_next = enable ? S_GAP : S_OFF;
`endif
      end
      S_GAP: begin
        lvl_next = '0;
        if (!enable) state_next = S_OFF;
        else if (off_reg == '0 || cnt_reg == off_reg - 1'b1) begin
          state_next = S_RAMP_UP;
          load       = 1'b1;
        end
        else cnt_next = cnt_reg + 1'b1;
      end
      default: state_next = S_OFF;
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_OFF;
      lvl_reg     <= '0;
      cnt_reg     <= '0;
      target_reg  <= '0;
      on_reg      <= '0;
      off_reg     <= '0;
      burst_start <= 1'b0;
      dac         <= STATIC_PATTERN;
    end else begin
      state_reg   <= state_next;
      lvl_reg     <= lvl_next;
      cnt_reg     <= cnt_next;
      burst_start <= load;
      dac         <= (noise_in & mask) | (STATIC_PATTERN & ~mask);
      if (load) begin
        target_reg <= live_target;
        on_reg     <= on_cycles;
        off_reg    <= off_cycles;
      end
    end
  end

endmodule

// File: tb/tb_noise_keyer.sv
// Randomized bench for noise_keyer against a phase/timeline reference model,
// plus directed checks of burst timing, mask values, clamping and reset.
module tb_noise_keyer;

  localparam int D = 4;
`ifdef NOISE_KEYER_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        rst_n;
  logic [15:0] noise_in;
  logic        enable;
  logic [4:0]  level;
  logic [23:0] on_cycles, off_cycles;
  logic [15:0] dac;
  logic [4:0]  cur_level;
  logic [2:0]  state;
  logic        burst_start;

  noise_keyer #(.RAMP_DIV(D), .CNT_W(24)) dut (
    .sclk(sclk), .rst_n(rst_n), .noise_in(noise_in), .enable(enable),
    .level(level), .on_cycles(on_cycles), .off_cycles(off_cycles),
    .dac(dac), .cur_level(cur_level), .state(state), .burst_start(burst_start)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0, n_err = 0, cyc = 0, n_burst = 0, lvl16_cyc = -1;
  int bs_q[$];
  bit rand_noise = 1'b1;

  // Reference model: phase (0 OFF,1 UP,2 ON,3 DOWN,4 GAP), cycles spent in phase.
  int m_phase, m_t, m_lvl, m_start, m_L, m_N, m_G;
  bit m_burst;
  logic [15:0] m_dac;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clampl(input int v);
    return (v > 16) ? 16 : v;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_lvl = 0; m_start = 0; m_burst = 0;
  endtask

  task automatic go(input int p);
    m_phase = p;
    m_t = 0;
  endtask

  task automatic sample_burst();
    m_L = clampl(int'(level));
    m_N = int'(on_cycles);
    m_G = int'(off_cycles);
    m_burst = 1'b1;
  endtask

  // Computes what the DUT shows after the coming clock edge.
  task automatic model_step();
    logic [31:0] mk;
    mk = (32'd1 << m_lvl) - 32'd1;
    m_dac = (noise_in & mk[15:0]) | (16'hAAAA & ~mk[15:0]);
    m_burst = 1'b0;
    case (m_phase)
      0: begin
        m_lvl = 0;
        if (enable) begin go(1); sample_burst(); end
      end
      1: begin
        if (!enable) begin m_start = m_lvl; go(3); end
        else if (RAMP_EN) begin
          if (m_t + 1 == max1(m_L) * D) begin m_lvl = m_L; go(2); end
          else begin
            m_t++;
            m_lvl = (m_t / D < m_L) ? m_t / D : m_L;
          end
        end
        else begin m_lvl = m_L; go(2); end
      end
      2: begin
        if (!enable) begin m_start = m_lvl; go(3); end
        else if (m_N == 0) begin
          if (RAMP_EN) begin
            m_t++;
            if (m_t % D == 0) begin
              if (m_lvl < clampl(int'(level)))      m_lvl++;
              else if (m_lvl > clampl(int'(level))) m_lvl--;
            end
          end
          else m_lvl = clampl(int'(level));
        end
        else if (m_t + 1 == m_N) begin m_start = m_lvl; go(3); end
        else m_t++;
      end
      3: begin
        if (RAMP_EN && m_t != m_start * D) begin
          m_t++;
          m_lvl = m_start - m_t / D;
        end
        else begin m_lvl = 0; go(enable ? 4 : 0); end
      end
      default: begin
        m_lvl = 0;
        if (!enable) go(0);
        else if (m_t + 1 >= max1(m_G)) begin go(1); sample_burst(); end
        else m_t++;
      end
    endcase
  endtask

  task automatic tick();
    if (rand_noise) noise_in = 16'($urandom);
    model_step();
    @(posedge sclk);
    @(negedge sclk);
    cyc++;
    check("state", 32'(state), 32'(m_phase));
    check("cur_level", 32'(cur_level), 32'(m_lvl));
    check("burst_start", 32'(burst_start), 32'(m_burst));
    check("dac", 32'(dac), 32'(m_dac));
    if (burst_start) begin
      n_burst++;
      bs_q.push_back(cyc);
      $display("burst %0d at cycle %0d: level=%0d on=%0d off=%0d", n_burst, cyc, m_L, m_N, m_G);
    end
    if (cur_level == 5'd16 && lvl16_cyc < 0) lvl16_cyc = cyc;
  endtask

  task automatic run_until_state(input int st, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      if (int'(state) == st) break;
      tick();
    end
    check(tag, 32'(state), 32'(st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k, nb;
    rst_n = 1'b0; enable = 1'b0; level = '0; on_cycles = '0; off_cycles = '0;
    noise_in = 16'h1234;
    model_reset();
    repeat (2) @(negedge sclk);
    check("rst_dac", 32'(dac), 32'h0000AAAA);
    check("rst_state", 32'(state), 32'd0);
    check("rst_level", 32'(cur_level), 32'd0);
    check("rst_burst", 32'(burst_start), 32'd0);
    rst_n = 1'b1;

    // Idle: OFF and static pattern whatever the noise does.
    repeat (100) tick();

    // Full burst cycle timing.
    level = 5'd16; on_cycles = 24'd100; off_cycles = 24'd50;
    bs_q.delete(); lvl16_cyc = -1;
    c0 = cyc;
    enable = 1'b1;
    for (int i = 0; i < 700 && bs_q.size() < 2; i++) tick();
    check("first_burst", (bs_q.size() > 0) ? 32'(bs_q[0]) : 32'd0, 32'(c0 + 1));
    check("lvl16_time", 32'(lvl16_cyc), 32'(c0 + 1 + (RAMP_EN ? 64 : 1)));
    check("burst_period", (bs_q.size() > 1) ? 32'(bs_q[1] - bs_q[0]) : 32'd0,
          RAMP_EN ? 32'd279 : 32'd152);
    enable = 1'b0;
    run_until_state(0, 300, "stop_off");

    // Mask at level 4 in continuous ON.
    level = 5'd4; on_cycles = 24'd0; enable = 1'b1;
    run_until_state(2, 100, "mask_on");
    rand_noise = 1'b0;
    noise_in = 16'h0000; tick();
    check("mask_zero", 32'(dac), 32'h0000AAA0);
    noise_in = 16'hFFFF; tick();
    check("mask_ones", 32'(dac), 32'h0000AAAF);
    rand_noise = 1'b1;
    enable = 1'b0;
    run_until_state(0, 100, "mask_off");

    // Clamp and continuous hold.
    level = 5'd20; on_cycles = 24'd0; enable = 1'b1;
    run_until_state(2, 100, "clamp_on");
    check("clamp_level", 32'(cur_level), 32'd16);
    repeat (200) tick();
    check("cont_on", 32'(state), 32'd2);

    // Asynchronous reset in ON.
    #2 rst_n = 1'b0;
    #1;
    check("async_dac", 32'(dac), 32'h0000AAAA);
    check("async_state", 32'(state), 32'd0);
    check("async_level", 32'(cur_level), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    run_until_state(2, 100, "post_rst_on");
    enable = 1'b0;
    run_until_state(0, 200, "post_rst_off");

`ifdef NOISE_KEYER_RAMP_EN
    // Enable dropped mid ramp-up at level 7.
    level = 5'd16; on_cycles = 24'd0; enable = 1'b1;
    for (int i = 0; i < 100 && cur_level != 5'd7; i++) tick();
    check("at_lvl7", 32'(cur_level), 32'd7);
    enable = 1'b0;
    tick();
    check("drop_down", 32'(state), 32'd3);
    k = 0;
    while (cur_level != 5'd0 && k < 100) begin tick(); k++; end
    check("down_cycles", 32'(k), 32'd28);
    nb = n_burst;
    tick();
    check("drop_off", 32'(state), 32'd0);
    repeat (20) tick();
    check("no_rebursts", 32'(n_burst - nb), 32'd0);
`else
    // Without ramps the level jumps straight to target.
    level = 5'd16; on_cycles = 24'd0; enable = 1'b1;
    tick(); tick();
    check("jump_16", 32'(cur_level), 32'd16);
    enable = 1'b0;
    run_until_state(0, 20, "jump_off");
`endif

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(149) == 0) enable = ~enable;
      if ($urandom_range(39) == 0) begin
        level      = 5'($urandom_range(31));
        on_cycles  = ($urandom_range(3) == 0) ? 24'd0 : 24'($urandom_range(60));
        off_cycles = 24'($urandom_range(30));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
